// File: rtl/four_bit_adder_pkg.sv
// Shared width and types for the registered ripple-carry adder.
// Consumed by four_bit_adder and its bench.
package four_bit_adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef logic [ADDER_WIDTH:0]   sum_t;

endpackage

// File: rtl/four_bit_adder_full_adder.sv
// One-bit full adder cell; the top chains WIDTH of these into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/four_bit_adder.sv
// Registered unsigned WIDTH-bit adder: ripple-carry core, one output register stage.
// Define FOUR_BIT_ADDER_OVF_EN to add a registered signed-overflow flag (port ovf).
module four_bit_adder
    import four_bit_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
`ifdef FOUR_BIT_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   sum,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   raw_sum;

    logic [WIDTH:0]   sum_d,       sum_q;
    logic             out_valid_d, out_valid_q;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (operand_a[i]),
            .b    (operand_b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    // Final carry lands in the MSB, so the result never wraps.
    assign raw_sum = {carry[WIDTH], sum_bits};

    // NOTE: defaults first in always_comb so every path assigns every output; no latches.
    always_comb begin
        sum_d       = sum_q;
        out_valid_d = in_valid;
        // Select by in_valid so operand X during idle cycles never reaches the register.
        if (in_valid) begin
            sum_d = raw_sum;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears all state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;

`ifdef FOUR_BIT_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Two's-complement overflow: same-sign operands giving an opposite-sign WIDTH-bit result.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                    (raw_sum[WIDTH-1] != operand_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed self-checking bench for four_bit_adder; inputs driven on the falling
// edge, outputs sampled 1 ns after the rising edge.
module tb_four_bit_adder;
    import four_bit_adder_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     in_valid;
    operand_t operand_a;
    operand_t operand_b;
    sum_t     sum;
    logic     out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
    logic     ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    four_bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
`ifdef FOUR_BIT_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .sum       (sum),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Apply one input set on the falling edge, then land just after the next rising edge.
    task automatic step(input logic v, input operand_t a, input operand_t b);
        @(negedge clk);
        in_valid  = v;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        operand_a = 4'hF;
        operand_b = 4'hF;
        #2;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, operand_t'(i * 5), 4'hA);
            n_checks++;
            if (sum !== 5'b00000 || out_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_hold[%0d]: sum=%b out_valid=%b, required sum=00000 out_valid=0",
                         i, sum, out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step(1'b0, 4'h0, 4'h0);
        n_checks++;
        if (sum !== 5'b00000 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: sum=%b out_valid=%b, required sum=00000 out_valid=0",
                     sum, out_valid);
        end
    endtask

    task automatic test_single_add();
        step(1'b1, 4'b1101, 4'b0011);
        n_checks++;
        if (sum !== 5'b10000 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL single_add: sum=%b out_valid=%b, required sum=10000 out_valid=1",
                     sum, out_valid);
        end
        step(1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (sum !== 5'b10000 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL single_idle: sum=%b out_valid=%b, required sum=10000 out_valid=0",
                     sum, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        operand_t a_vec [3] = '{4'b1111, 4'b1111, 4'b0000};
        operand_t b_vec [3] = '{4'b0001, 4'b1111, 4'b0000};
        sum_t     s_exp [3] = '{5'b10000, 5'b11110, 5'b00000};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a_vec[i], b_vec[i]);
            n_checks++;
            if (sum !== s_exp[i] || out_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL back_to_back[%0d]: sum=%b out_valid=%b, required sum=%b out_valid=1",
                         i, sum, out_valid, s_exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b1, 4'b0101, 4'b0010);
        n_checks++;
        if (sum !== 5'b00111 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL hold_accept: sum=%b out_valid=%b, required sum=00111 out_valid=1",
                     sum, out_valid);
        end
        step(1'b0, 4'b1111, 4'b1111);
        n_checks++;
        if (sum !== 5'b00111 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_idle: sum=%b out_valid=%b, required sum=00111 out_valid=0",
                     sum, out_valid);
        end
        step(1'b0, 4'bxxxx, 4'bxxxx);
        n_checks++;
        if (sum !== 5'b00111 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_x_operands: sum=%b out_valid=%b, required sum=00111 out_valid=0",
                     sum, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 4'b1001, 4'b1000);
        n_checks++;
        if (sum !== 5'b10001 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL midrst_pre: sum=%b out_valid=%b, required sum=10001 out_valid=1",
                     sum, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sum !== 5'b00000 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_async: sum=%b out_valid=%b, required sum=00000 out_valid=0",
                     sum, out_valid);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step(1'b1, 4'b0011, 4'b0100);
        n_checks++;
        if (sum !== 5'b00111 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL midrst_first: sum=%b out_valid=%b, required sum=00111 out_valid=1",
                     sum, out_valid);
        end
    endtask

`ifdef FOUR_BIT_ADDER_OVF_EN
    task automatic test_ovf();
        operand_t a_vec [3] = '{4'b0111, 4'b1000, 4'b1101};
        operand_t b_vec [3] = '{4'b0001, 4'b1000, 4'b0011};
        sum_t     s_exp [3] = '{5'b01000, 5'b10000, 5'b10000};
        logic     o_exp [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a_vec[i], b_vec[i]);
            n_checks++;
            if (sum !== s_exp[i] || ovf !== o_exp[i]) begin
                n_fails++;
                $display("FAIL ovf[%0d]: sum=%b ovf=%b, required sum=%b ovf=%b",
                         i, sum, ovf, s_exp[i], o_exp[i]);
            end
        end
        step(1'b1, 4'b0111, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_hold: ovf=%b, required 1", ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_reset: ovf=%b, required 0", ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
`ifdef FOUR_BIT_ADDER_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
Registered unsigned adder for two 4-bit operands, producing a 5-bit sum that includes the carry-out. The datapath is a ripple-carry chain of full-adder cells with a single output register stage. It serves as a small arithmetic leaf block in larger datapaths and has a simple valid qualifier on input and output.

Parameters:
WIDTH, 4, operand width in bits. The sum is WIDTH+1 bits. Only 4 is required to be verified; other values must still elaborate.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle; sample and add
operand_a  input  WIDTH  unsigned addend A
operand_b  input  WIDTH  unsigned addend B
sum  output  WIDTH+1  registered A+B; MSB is carry-out
out_valid  output  1  sum updated from an accepted input on the previous edge

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert use):
  - sum = 0.
  - out_valid = 0.
  - Any in-flight result is discarded.
- Arithmetic:
  - sum = zero_extend(operand_a) + zero_extend(operand_b), computed at full WIDTH+1 bits.
  - No wrap: the carry from bit WIDTH-1 lands in sum[WIDTH].
  - Carry-in to bit 0 is constant 0.
- Combinational core: ripple chain of WIDTH full_adder instances.
  - Per bit i: s_i = a_i ^ b_i ^ c_i, c_(i+1) = a_i&b_i | c_i&(a_i^b_i).
  - c_0 = 0; c_WIDTH drives the sum MSB.
- Latency: exactly 1 clock.
  - Operands with in_valid=1 at edge N appear on sum with out_valid=1 after edge N.
- in_valid=0 at an edge:
  - sum holds its previous value (no update, no clear).
  - out_valid goes to 0.
- Back-to-back in_valid=1: new result every cycle, out_valid stays 1. No stall, no backpressure.
- Operands are ignored whenever in_valid=0; X on operands while in_valid=0 must not propagate to sum.
- Boundary cases:
  - 4'hF+4'hF -> 5'h1E.
  - 4'h0+4'h0 -> 5'h00, with out_valid=1 if in_valid was 1.
- Reset asserted mid-stream: outputs go to 0 immediately (asynchronous). The first valid result after deassert appears one edge after the first accepted input.

Optional Feature:
Macro FOUR_BIT_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit, the signed two's-complement overflow of the WIDTH-bit sum: ovf = (a[MSB]==b[MSB]) && (sum[WIDTH-1]!=a[MSB]).
  - ovf is registered alongside sum: same enable, same hold behaviour, reset value 0.
- Undefined:
  - Port ovf and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package four_bit_adder_pkg holds:
  - localparam ADDER_WIDTH = 4.
  - typedef operand_t (logic [ADDER_WIDTH-1:0]).
  - typedef sum_t (logic [ADDER_WIDTH:0]).
- One sub-module, full_adder (a, b, cin -> s, cout), instantiated WIDTH times in a generate loop.
- The top level holds the carry chain wiring and the output register.

Test Plan:
- Reset low, then release with in_valid=0 -> sum=5'b00000, out_valid=0; during reset, toggling operands has no effect.
- in_valid=1, a=4'b1101, b=4'b0011 for one cycle -> next cycle sum=5'b10000, out_valid=1; following idle cycle out_valid=0, sum holds 5'b10000.
- Back-to-back accepted inputs:
  - Sequence (4'b1111,4'b0001), (4'b1111,4'b1111), (4'b0000,4'b0000).
  - Expect sums 5'b10000, 5'b11110, 5'b00000 on consecutive cycles with out_valid held at 1.
- Hold behaviour: accept (4'b0101,4'b0010) -> sum=5'b00111. Then in_valid=0 with a=4'b1111, b=4'b1111 -> sum stays 5'b00111.
- Reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> sum=0 and out_valid=0 immediately. After release, accept (4'b0011,4'b0100) -> sum=5'b00111 one cycle later.
- With FOUR_BIT_ADDER_OVF_EN defined:
  - (4'b0111,4'b0001) -> sum=5'b01000, ovf=1.
  - (4'b1000,4'b1000) -> sum=5'b10000, ovf=1.
  - (4'b1101,4'b0011) -> ovf=0.
